// File: rtl/period_meter_pkg.sv
// Shared clocking constants for the divider / measurement blocks.
// Period and timeout defaults of period_meter are derived from these.
package period_meter_pkg;

  localparam int unsigned BASIC_CLOCK_RATE = 100_000_000;
  localparam int unsigned CLOCK_WIDTH      = 27;
  // Half-period count of a 1 Hz divider output.
  localparam int unsigned ONE_HZ_COUNT     = BASIC_CLOCK_RATE / 2;

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchronizer with single-cycle rising/falling edge pulses.
// Reusable for any slow asynchronous input (buttons, divided clocks).
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise_p,
  output logic fall_p,
  output logic level
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_p = s2 & ~s3;
  assign fall_p = ~s2 & s3;
  assign level  = s2;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, with a sticky timeout when no rising edge arrives in time.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = CLOCK_WIDTH,
  parameter int unsigned TIMEOUT_COUNT = ONE_HZ_COUNT * 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 timeout
);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_MEAS = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hcnt;
  logic                 rise_p;
  logic                 fall_p;
  logic                 level;
  logic                 hcnt_inc;

  edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise_p (rise_p),
    .fall_p (fall_p),
    .level  (level)
  );

  // High-time counting stops once the synchronized input has fallen.
  assign hcnt_inc = level & ~fall_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_WAIT: begin
          cnt  <= '0;
          hcnt <= '0;
          // First edge only arms; a full period is needed before reporting.
          if (en && rise_p) begin
            cnt   <= CNT_ONE;
            hcnt  <= CNT_ONE;
            state <= S_MEAS;
          end
        end
        S_MEAS: begin
          if (!en) begin
            cnt   <= '0;
            hcnt  <= '0;
            state <= S_WAIT;
          end else if (rise_p) begin
            period    <= cnt;
            high_time <= hcnt;
            valid     <= 1'b1;
            timeout   <= 1'b0;
            cnt       <= CNT_ONE;
            hcnt      <= CNT_ONE;
          end else if (cnt == TIMEOUT_VAL) begin
            timeout <= 1'b1;
            cnt     <= '0;
            hcnt    <= '0;
            state   <= S_WAIT;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (hcnt_inc) begin
              hcnt <= hcnt + CNT_ONE;
            end
          end
        end
        default: begin
          cnt   <= '0;
          hcnt  <= '0;
          state <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: edge-timestamp reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_period_meter;

  localparam int unsigned CW = 8;
  localparam int unsigned TC = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  period_meter #(.CNT_WIDTH(CW), .TIMEOUT_COUNT(TC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: sig_in history at previous edges, rise timestamps,
  // and a tally of high samples since the last measured rise.
  bit m_live = 1'b0;
  bit h1, h2, h3;
  int e_no = 0;
  bit armed = 1'b0;
  int last_rise = 0;
  int hsum = 0;
  int m_period = 0;
  int m_high = 0;
  bit m_valid = 1'b0;
  bit m_timeout = 1'b0;

  always @(posedge clk) begin : model
    bit rise;
    bit lvl;
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      armed = 1'b0;
      m_period = 0; m_high = 0; m_valid = 1'b0; m_timeout = 1'b0;
      m_live = 1'b1;
    end else begin
      rise = h2 && !h3;
      lvl  = h2;
      m_valid = 1'b0;
      if (armed) begin
        if (!en) begin
          armed = 1'b0;
        end else if (rise) begin
          m_period  = e_no - last_rise;
          m_high    = hsum;
          m_valid   = 1'b1;
          m_timeout = 1'b0;
          last_rise = e_no;
          hsum      = 1;
        end else if (e_no - last_rise == int'(TC)) begin
          m_timeout = 1'b1;
          armed     = 1'b0;
        end else if (lvl) begin
          hsum = hsum + 1;
        end
      end else if (en && rise) begin
        armed     = 1'b1;
        last_rise = e_no;
        hsum      = 1;
      end
      h3 = h2; h2 = h1; h1 = sig_in;
    end
    e_no = e_no + 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      checks = checks + 1;
      if (valid !== m_valid || timeout !== m_timeout ||
          period !== CW'(m_period) || high_time !== CW'(m_high)) begin
        errors = errors + 1;
        $display("FAIL model_cmp t=%0t valid=%b want %b timeout=%b want %b period=%0d want %0d high_time=%0d want %0d",
                 $time, valid, m_valid, timeout, m_timeout, period, m_period, high_time, m_high);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  int  w_seen, w_skip, w_exp_p, w_exp_h;
  time w_last;

  task automatic begin_wave(input int skip, input int exp_p, input int exp_h);
    w_seen  = 0;
    w_skip  = skip;
    w_exp_p = exp_p;
    w_exp_h = exp_h;
    w_last  = 0;
  endtask

  // Literal checks on each valid; the first `skip` valids report the
  // period that straddles the previous scenario and are only counted.
  task automatic obs();
    if (valid) begin
      w_seen = w_seen + 1;
      if (w_seen > w_skip) begin
        chk("period", int'(period), w_exp_p);
        chk("high_time", int'(high_time), w_exp_h);
        if (w_seen > w_skip + 1)
          chk("valid_spacing", int'(($time - w_last) / 10), w_exp_p);
      end
      w_last = $time;
    end
  endtask

  task automatic end_wave(input int n);
    chk("valid_count", w_seen, n);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi + lo; i++) begin
        @(negedge clk);
        obs();
        sig_in = (i < hi);
      end
    end
  endtask

  // Stand-in for a divider toggling its output every k cycles.
  task automatic divider(input int k, input int cycles);
    int  c;
    bit  phase;
    c = 0;
    phase = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      obs();
      sig_in = phase;
      c = c + 1;
      if (c == k) begin
        c = 0;
        phase = !phase;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int first;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(valid), 0);
    chk("reset_timeout", int'(timeout), 0);
    chk("reset_period", int'(period), 0);
    chk("reset_high_time", int'(high_time), 0);
    rst = 1'b0;

    // Steady 4/4 wave: first rise only arms.
    begin_wave(0, 8, 4);
    wave(4, 4, 6);
    end_wave(5);

    // Asymmetric duty, then a duty change.
    begin_wave(1, 10, 3);
    wave(3, 7, 4);
    end_wave(4);
    begin_wave(1, 10, 6);
    wave(6, 4, 3);
    end_wave(3);

    // Timeout: one rise, then held low.
    begin_wave(0, 10, 6);
    first = -1;
    @(negedge clk);
    sig_in = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      obs();
      if (timeout && first < 0) first = i;
      if (i == 4) sig_in = 1'b0;
    end
    end_wave(1);
    chk("timeout_latency", first, 67);
    chk("period_held_on_timeout", int'(period), 10);
    chk("high_held_on_timeout", int'(high_time), 6);

    // Recovery after timeout needs two rises.
    begin_wave(0, 8, 4);
    wave(4, 4, 3);
    end_wave(2);
    chk("timeout_cleared", int'(timeout), 0);

    // Boundary: period exactly TIMEOUT_COUNT is still measured.
    begin_wave(1, 64, 32);
    wave(32, 32, 3);
    end_wave(3);
    chk("no_timeout_at_64", int'(timeout), 0);

    // Period of 65 times out instead.
    begin_wave(0, 64, 32);
    wave(32, 33, 2);
    end_wave(1);
    chk("timeout_at_65", int'(timeout), 1);

    // Reset mid-period clears everything.
    @(negedge clk);
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sig_in = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_high_time", int'(high_time), 0);
    rst = 1'b0;
    begin_wave(0, 8, 4);
    wave(4, 4, 3);
    end_wave(2);

    // Enable low for 20 cycles: no valids, outputs hold.
    en = 1'b0;
    begin_wave(0, 0, 0);
    wave(5, 5, 2);
    end_wave(0);
    chk("en_hold_period", int'(period), 8);
    chk("en_hold_high", int'(high_time), 4);
    chk("en_hold_timeout", int'(timeout), 0);
    en = 1'b1;
    begin_wave(0, 8, 4);
    wave(4, 4, 3);
    end_wave(2);

    // Divider with count 5 reads back as 10 / 5.
    begin_wave(1, 10, 5);
    divider(5, 60);
    end_wave(6);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow asynchronous square-wave input, counted in `clk` cycles. It is the receiving end of the frequency-divider outputs: divided clocks, button-scan ticks and external signals can be checked against their programmed counts. A divider programmed with NUMBER_OF_COUNT = K must read back as period 2K and high time K. Results go to the SSD/VGA debug overlays and to self-check logic.

## Interface
- `CNT_WIDTH`, default 27: width of the counters and result ports. It must satisfy TIMEOUT_COUNT ≤ 2^CNT_WIDTH − 1.
- `TIMEOUT_COUNT`, default 100_000_000: the largest measurable period in cycles (1 s at 100 MHz).
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: measurement enable.
- `sig_in`  in  1: asynchronous signal under measurement.
- `period`  out  CNT_WIDTH: last measured period in cycles. Reset value 0.
- `high_time`  out  CNT_WIDTH: high time of that same period. Reset value 0.
- `valid`  out  1: one-cycle pulse when `period` and `high_time` update. Reset value 0.
- `timeout`  out  1: sticky flag meaning no rising edge arrived within TIMEOUT_COUNT cycles. Reset value 0.

## Operation
- **Input conditioning**
  - Flops s1→s2→s3 synchronize `sig_in`. All three reset to 0.
  - rise_p = s2 & ~s3.
  - fall_p = ~s2 & s3.
  - level = s2.
- **States:** S_WAIT (reset state) and S_MEAS.
- **S_WAIT**
  - `cnt` and `hcnt` hold at 0.
  - On rise_p with en=1: cnt←1, hcnt←1, go to S_MEAS. No `valid` is produced.
- **S_MEAS, each cycle, in priority order:**
  1. en=0: go to S_WAIT, clear cnt and hcnt. Outputs hold their values.
  2. rise_p: period←cnt, high_time←hcnt, valid←1, timeout←0, cnt←1, hcnt←1. Stay in S_MEAS.
  3. cnt == TIMEOUT_COUNT: timeout←1, go to S_WAIT. `period` and `high_time` hold.
  4. Otherwise: cnt←cnt+1, and hcnt←hcnt+1 if level=1, else hcnt holds.
- **Counter semantics**
  - `cnt` is the number of cycles since the last rise_p, including the current cycle.
  - Steady edges every N cycles therefore give period = N.
  - A high phase of H synchronized cycles gives high_time = H.
- **Boundary conditions**
  - A rise_p in the same cycle that cnt == TIMEOUT_COUNT counts as an edge: valid, period = TIMEOUT_COUNT, no timeout.
  - Counters never wrap, because the timeout fires first.
  - fall_p only stops `hcnt`; it has no other effect.
  - Minimum measurable input is 2 cycles per phase. Narrower pulses may be lost in synchronization; this is not an error.
- **en=0** suppresses valid and timeout updates. After en rises, the first rise_p only arms the measurement; the second produces `valid`.
- **rst** has priority over everything. All flops and outputs clear and the state returns to S_WAIT. A rst asserted mid-measurement discards the partial count.

## Timing
- sig_in high at sampling edge k: s2=1 after edge k+1, so rise_p is asserted in the cycle after edge k+1.
- valid, period and high_time update at edge k+2, all on the same edge. Latency is 3 edges from the first sampling edge.
- `valid` is high for exactly one cycle per rising edge of the input. Consecutive valids are at least 2 cycles apart.
- `timeout` rises at the edge where S_MEAS sees cnt == TIMEOUT_COUNT without rise_p. That is TIMEOUT_COUNT cycles after the last rise_p.
- `timeout` clears at the edge that raises `valid`.
- All outputs are registered; there is no combinational path from `sig_in` or `en`.

## Structure
- The shared constants header keeps BASIC_CLOCK_RATE, CLOCK_WIDTH and ONE_HZ_COUNT. The TIMEOUT_COUNT default is ONE_HZ_COUNT×2, and the CNT_WIDTH default is CLOCK_WIDTH.
- State encodings S_WAIT=1'b0 and S_MEAS=1'b1 are local parameters of this block and are not shared.
- One sub-module, `edge_sync`, holds the 3-flop synchronizer and edge detector. It has a sync active-high rst and outputs rise_p, fall_p and level. It is reusable for the button inputs.

## Test plan
- **Steady 50% wave:** sig_in 4 high / 4 low, en=1. The first rise gives no valid. Every later rise gives valid with period=8 and high_time=4, with valid pulses exactly 8 cycles apart.
- **Asymmetric duty:** 3 high / 7 low gives period=10, high_time=3. Changing to 6 high / 4 low gives period=10, high_time=6 on the first full new period.
- **Timeout:** TIMEOUT_COUNT=64; sig_in held low after a rise. timeout=1 exactly 64 cycles after that rise_p, period and high_time unchanged. Edges every 8 then give no valid on the first rise; the second rise gives valid and timeout=0.
- **Boundary:** TIMEOUT_COUNT=64 and sig_in period exactly 64 gives valid with period=64 and timeout stays 0. A period of 65 gives timeout=1 and no valid.
- **Reset and enable:** assert rst mid-period. Next cycle all outputs are 0 and the state is S_WAIT; after release the first rise gives no valid. Separately, drop en for 20 cycles: no valid during that time, outputs hold, and re-arming needs two rises.
- **Divider cross-check:** FrequencyDivider with NUMBER_OF_COUNT=5 drives sig_in; the block reports period=10, high_time=5 repeatedly.
